// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS controller: opcodes,
// state encoding, instruction classes and datapath select encodings.
package mc_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALU_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_B      = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_R_EXEC    = 4'd2,
        ST_R_WB      = 4'd3,
        ST_ADDI_EXEC = 4'd4,
        ST_ADDI_WB   = 4'd5,
        ST_MEM_ADDR  = 4'd6,
        ST_MEM_READ  = 4'd7,
        ST_MEM_WB    = 4'd8,
        ST_MEM_WRITE = 4'd9,
        ST_BRANCH    = 4'd10,
        ST_JUMP      = 4'd11,
        ST_TRAP      = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        CLS_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J, CLS_ILLEGAL
    } inst_class_e;

    typedef struct packed {
        logic             pc_write;
        logic             iord;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             mem_to_reg;
        logic             reg_write;
        logic             reg_dst;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] pc_source;
        logic             illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath bundle: IR opcode/status in, control word out.
interface mc_control_fsm_if;
    import mc_ctrl_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;
    logic                pc_write;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_write;
    logic                reg_dst;
    logic                alu_src_a;
    logic [SEL_W-1:0]    alu_src_b;
    logic [SEL_W-1:0]    alu_op;
    logic [SEL_W-1:0]    pc_source;
    logic                illegal_op;
    logic [STATE_W-1:0]  state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg,
               reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal_op, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg,
               reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal_op, state
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode -> instruction class lookup.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output inst_class_e         inst_class
);
    always_comb begin
        inst_class = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE: inst_class = CLS_R;
            OP_ADDI:  inst_class = CLS_ADDI;
            OP_LW:    inst_class = CLS_LW;
            OP_SW:    inst_class = CLS_SW;
            OP_BEQ:   inst_class = CLS_BEQ;
            OP_BNE:   inst_class = CLS_BNE;
            OP_J:     inst_class = CLS_J;
            default:  inst_class = CLS_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: state register, next-state logic and
// control-word decode, with memory-ready stalls and illegal-opcode trapping.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN     = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    mc_control_fsm_if.master  bus
);
    state_e      state_q;
    state_e      state_d;
    inst_class_e inst_class;
    ctrl_t       ctrl;
    logic        ready;

    mc_ctrl_decode u_decode (
        .opcode     (bus.opcode),
        .inst_class (inst_class)
    );

    assign ready = bus.mem_ready | ~MEM_WAIT_EN;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = ready;
                ctrl.pc_write  = ready;
                if (ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // Speculative branch target goes into ALUOut here.
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
                case (inst_class)
                    CLS_R:             state_d = ST_R_EXEC;
                    CLS_ADDI:          state_d = ST_ADDI_EXEC;
                    CLS_LW, CLS_SW:    state_d = ST_MEM_ADDR;
                    CLS_BEQ, CLS_BNE:  state_d = ST_BRANCH;
                    CLS_J:             state_d = ST_JUMP;
                    default: begin
                        ctrl.illegal_op = ~TRAP_ON_ILLEGAL;
                        state_d = TRAP_ON_ILLEGAL ? ST_TRAP : ST_FETCH;
                    end
                endcase
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
                state_d        = ST_R_WB;
            end
            ST_R_WB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_d        = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_d = (inst_class == CLS_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
                if (ready) state_d = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                state_d         = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                if (ready) state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_write  = (inst_class == CLS_BNE) ? ~bus.zero : bus.zero;
                state_d        = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_TRAP: begin
                ctrl.illegal_op = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
        // No strobe may fire while reset is being sampled.
        if (reset) ctrl = '0;
    end

    assign bus.pc_write   = ctrl.pc_write;
    assign bus.iord       = ctrl.iord;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.pc_source  = ctrl.pc_source;
    assign bus.illegal_op = ctrl.illegal_op;
    assign bus.state      = reset ? STATE_W'(0) : STATE_W'(state_q);
endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboarded directed test of mc_control_fsm across three parameter sets.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    always #5 clk = ~clk;

    mc_control_fsm_if if_a ();
    mc_control_fsm_if if_b ();
    mc_control_fsm_if if_c ();

    assign if_a.opcode = opcode;  assign if_a.zero = zero;  assign if_a.mem_ready = mem_ready;
    assign if_b.opcode = opcode;  assign if_b.zero = zero;  assign if_b.mem_ready = mem_ready;
    assign if_c.opcode = opcode;  assign if_c.zero = zero;  assign if_c.mem_ready = mem_ready;

    mc_control_fsm #(.MEM_WAIT_EN(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    mc_control_fsm #(.MEM_WAIT_EN(1'b1), .TRAP_ON_ILLEGAL(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
    mc_control_fsm #(.MEM_WAIT_EN(1'b0), .TRAP_ON_ILLEGAL(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

    // Observed word: {state, pc_write, iord, mem_read, mem_write, ir_write,
    // mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
    logic [19:0] act_a, act_b, act_c;
    assign act_a = {if_a.state, if_a.pc_write, if_a.iord, if_a.mem_read, if_a.mem_write, if_a.ir_write,
                    if_a.mem_to_reg, if_a.reg_write, if_a.reg_dst, if_a.alu_src_a, if_a.alu_src_b,
                    if_a.alu_op, if_a.pc_source, if_a.illegal_op};
    assign act_b = {if_b.state, if_b.pc_write, if_b.iord, if_b.mem_read, if_b.mem_write, if_b.ir_write,
                    if_b.mem_to_reg, if_b.reg_write, if_b.reg_dst, if_b.alu_src_a, if_b.alu_src_b,
                    if_b.alu_op, if_b.pc_source, if_b.illegal_op};
    assign act_c = {if_c.state, if_c.pc_write, if_c.iord, if_c.mem_read, if_c.mem_write, if_c.ir_write,
                    if_c.mem_to_reg, if_c.reg_write, if_c.reg_dst, if_c.alu_src_a, if_c.alu_src_b,
                    if_c.alu_op, if_c.pc_source, if_c.illegal_op};

    // Strobe field order: pcw iord mrd mwr irw m2r rwr rdst asa
    localparam logic [19:0] E_RST    = 20'h0;
    localparam logic [19:0] E_F_RDY  = {4'd0,  9'b1_0_1_0_1_0_0_0_0, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_F_WAIT = {4'd0,  9'b0_0_1_0_0_0_0_0_0, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_DEC    = {4'd1,  9'b0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_DEC_IL = {4'd1,  9'b0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 2'b00, 1'b1};
    localparam logic [19:0] E_REX    = {4'd2,  9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [19:0] E_RWB    = {4'd3,  9'b0_0_0_0_0_0_1_1_0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_AEX    = {4'd4,  9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_AWB    = {4'd5,  9'b0_0_0_0_0_0_1_0_0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_MAD    = {4'd6,  9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_MRD    = {4'd7,  9'b0_1_1_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_MWB    = {4'd8,  9'b0_0_0_0_0_1_1_0_0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_MWR    = {4'd9,  9'b0_1_0_1_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [19:0] E_BR_T   = {4'd10, 9'b1_0_0_0_0_0_0_0_1, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [19:0] E_BR_N   = {4'd10, 9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [19:0] E_JMP    = {4'd11, 9'b1_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [19:0] E_TRAP   = {4'd12, 9'b0_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 1'b1};

    typedef struct {
        int          dut;
        logic [19:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Monitor: every cycle the DUT presents a control word; compare on the falling edge.
    initial begin
        exp_t        e;
        logic [19:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.dut)
                    0:       act = act_a;
                    1:       act = act_b;
                    default: act = act_c;
                endcase
                n_cmp++;
                if (act !== e.exp) begin
                    n_err++;
                    $display("FAIL %s (dut %0d): got %h expected %h", e.name, e.dut, act, e.exp);
                end
            end
        end
    end

    task automatic cyc(input int d, input logic rst, input logic [5:0] op, input logic z,
                       input logic rdy, input logic [19:0] e, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        reset = rst; opcode = op; zero = z; mem_ready = rdy;
        x.dut = d; x.exp = e; x.name = nm;
        sb_q.push_back(x);
    endtask

    localparam logic [5:0] OPX = 6'b111111;

    initial begin
        // dut_a: wait-enabled, trapping
        cyc(0, 1'b1, 6'h00, 1'b0, 1'b1, E_RST, "reset_cycle");
        cyc(0, 1'b1, 6'h00, 1'b0, 1'b1, E_RST, "reset_hold");

        cyc(0, 1'b0, 6'b000000, 1'b0, 1'b1, E_F_RDY, "r_fetch");
        cyc(0, 1'b0, 6'b000000, 1'b0, 1'b1, E_DEC,   "r_decode");
        cyc(0, 1'b0, 6'b000000, 1'b0, 1'b1, E_REX,   "r_exec");
        cyc(0, 1'b0, 6'b000000, 1'b0, 1'b1, E_RWB,   "r_wb");

        cyc(0, 1'b0, 6'b001000, 1'b0, 1'b0, E_F_WAIT, "addi_fetch_wait");
        cyc(0, 1'b0, 6'b001000, 1'b0, 1'b1, E_F_RDY,  "addi_fetch");
        cyc(0, 1'b0, 6'b001000, 1'b0, 1'b0, E_DEC,    "addi_decode");
        cyc(0, 1'b0, 6'b001000, 1'b0, 1'b0, E_AEX,    "addi_exec");
        cyc(0, 1'b0, 6'b001000, 1'b0, 1'b1, E_AWB,    "addi_wb");

        cyc(0, 1'b0, 6'b100011, 1'b0, 1'b1, E_F_RDY, "lw_fetch");
        cyc(0, 1'b0, 6'b100011, 1'b0, 1'b1, E_DEC,   "lw_decode");
        cyc(0, 1'b0, 6'b100011, 1'b0, 1'b1, E_MAD,   "lw_addr");
        cyc(0, 1'b0, 6'b100011, 1'b0, 1'b0, E_MRD,   "lw_read_wait1");
        cyc(0, 1'b0, 6'b100011, 1'b0, 1'b0, E_MRD,   "lw_read_wait2");
        cyc(0, 1'b0, 6'b100011, 1'b0, 1'b1, E_MRD,   "lw_read_done");
        cyc(0, 1'b0, 6'b100011, 1'b0, 1'b1, E_MWB,   "lw_wb");

        cyc(0, 1'b0, 6'b000100, 1'b1, 1'b1, E_F_RDY, "beq_fetch");
        cyc(0, 1'b0, 6'b000100, 1'b1, 1'b1, E_DEC,   "beq_decode");
        cyc(0, 1'b0, 6'b000100, 1'b1, 1'b1, E_BR_T,  "beq_taken");

        cyc(0, 1'b0, 6'b000101, 1'b1, 1'b1, E_F_RDY, "bne_fetch");
        cyc(0, 1'b0, 6'b000101, 1'b1, 1'b1, E_DEC,   "bne_decode");
        cyc(0, 1'b0, 6'b000101, 1'b1, 1'b1, E_BR_N,  "bne_not_taken");

        cyc(0, 1'b0, 6'b000101, 1'b0, 1'b1, E_F_RDY, "bne2_fetch");
        cyc(0, 1'b0, 6'b000101, 1'b0, 1'b1, E_DEC,   "bne2_decode");
        cyc(0, 1'b0, 6'b000101, 1'b0, 1'b1, E_BR_T,  "bne_taken");

        cyc(0, 1'b0, 6'b101011, 1'b0, 1'b1, E_F_RDY, "sw_fetch");
        cyc(0, 1'b0, 6'b101011, 1'b0, 1'b1, E_DEC,   "sw_decode");
        cyc(0, 1'b0, 6'b101011, 1'b0, 1'b1, E_MAD,   "sw_addr");
        cyc(0, 1'b0, 6'b101011, 1'b0, 1'b0, E_MWR,   "sw_write_wait");
        cyc(0, 1'b1, 6'b101011, 1'b0, 1'b0, E_RST,   "sw_reset_in_write");
        cyc(0, 1'b0, 6'b101011, 1'b0, 1'b1, E_F_RDY, "sw_after_reset");
        cyc(0, 1'b0, 6'b101011, 1'b0, 1'b1, E_DEC,   "sw2_decode");
        cyc(0, 1'b0, 6'b101011, 1'b0, 1'b1, E_MAD,   "sw2_addr");
        cyc(0, 1'b0, 6'b101011, 1'b0, 1'b1, E_MWR,   "sw2_write");

        cyc(0, 1'b0, OPX, 1'b0, 1'b1, E_F_RDY, "ill_fetch");
        cyc(0, 1'b0, OPX, 1'b0, 1'b1, E_DEC,   "ill_decode_trap");
        for (int i = 0; i < 10; i++)
            cyc(0, 1'b0, OPX, 1'b0, 1'b1, E_TRAP, "trap_sticky");
        cyc(0, 1'b1, OPX, 1'b0, 1'b1, E_RST,   "trap_reset");
        cyc(0, 1'b0, OPX, 1'b0, 1'b1, E_F_RDY, "trap_exit_fetch");

        // dut_b: illegal opcode is a NOP with a one-cycle pulse
        cyc(1, 1'b1, OPX, 1'b0, 1'b1, E_RST,    "b_reset");
        cyc(1, 1'b0, OPX, 1'b0, 1'b1, E_F_RDY,  "b_ill_fetch");
        cyc(1, 1'b0, OPX, 1'b0, 1'b1, E_DEC_IL, "b_ill_pulse");
        cyc(1, 1'b0, 6'b000010, 1'b0, 1'b1, E_F_RDY, "b_back_to_fetch");
        cyc(1, 1'b0, 6'b000010, 1'b0, 1'b1, E_DEC,   "b_j_decode");
        cyc(1, 1'b0, 6'b000010, 1'b0, 1'b1, E_JMP,   "b_jump");

        // dut_c: single-cycle memory, mem_ready tied low
        cyc(2, 1'b1, 6'b000010, 1'b0, 1'b0, E_RST,   "c_reset");
        cyc(2, 1'b0, 6'b000010, 1'b0, 1'b0, E_F_RDY, "c_j_fetch");
        cyc(2, 1'b0, 6'b000010, 1'b0, 1'b0, E_DEC,   "c_j_decode");
        cyc(2, 1'b0, 6'b000010, 1'b0, 1'b0, E_JMP,   "c_jump");
        cyc(2, 1'b0, 6'b100011, 1'b0, 1'b0, E_F_RDY, "c_lw_fetch");
        cyc(2, 1'b0, 6'b100011, 1'b0, 1'b0, E_DEC,   "c_lw_decode");
        cyc(2, 1'b0, 6'b100011, 1'b0, 1'b0, E_MAD,   "c_lw_addr");
        cyc(2, 1'b0, 6'b100011, 1'b0, 1'b0, E_MRD,   "c_lw_read");
        cyc(2, 1'b0, 6'b100011, 1'b0, 1'b0, E_MWB,   "c_lw_wb");
        cyc(2, 1'b0, 6'b100011, 1'b0, 1'b0, E_F_RDY, "c_next_fetch");

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
